tile_row_fetch: RTL and testbench

- Upstream producer for the two-entry ping-pong buffer that feeds the pixel output path.
- On a fetch request it reads one tile row from a synchronous pattern ROM of fixed latency and optionally mirrors it.
- It then presents the row word with a one-cycle write strobe. The buffer toggles on that strobe, so the reader sees the new row.
- Exactly one strobe per accepted request; requests arriving while busy are dropped and flagged.

---
 rtl/tile_row_fetch_pkg.sv | 17 +
 rtl/tile_row_fetch_row_mirror.sv | 20 ++
 rtl/tile_row_fetch.sv | 146 ++++++++++++++
 tb/tb_tile_row_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_row_fetch_pkg.sv
// Shared definitions for tile_row_fetch.
//   - Fetch FSM state type (IDLE=0, REQ=1, WAIT=2, DONE=3)
//   - Default tile / row index widths and the derived ROM address width
package tile_row_fetch_pkg;

  localparam int unsigned TILE_W_DEF = 8;
  localparam int unsigned ROW_W_DEF  = 3;
  localparam int unsigned ADDR_W_DEF = TILE_W_DEF + ROW_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/tile_row_fetch_row_mirror.sv
// row_mirror: combinational bit reversal of one tile row word, used to
// mirror a row horizontally (MSB = leftmost pixel).
// Ports:
//   din  in  DATA_WIDTH  row word as read from the pattern ROM
//   dout out DATA_WIDTH  bit-reversed row word
module row_mirror #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      dout[i] = din[DATA_WIDTH-1-i];
    end
  end

endmodule

// File: rtl/tile_row_fetch.sv
// tile_row_fetch: fetches one tile row from a fixed-latency synchronous
// pattern ROM and hands it to the ping-pong row buffer with a one-cycle
// write strobe. One strobe per accepted request; requests while busy are
// dropped and flagged on odrop.
//
// Optional feature macro: TILE_ROW_FETCH_FLIP_EN
//   defined   : latched iflip mirrors the row word (row_mirror instance)
//   undefined : iflip ignored, data passes straight through
//
// Ports:
//   iclk       in  1             clock
//   irst_n     in  1             asynchronous active-low reset
//   istart     in  1             fetch request pulse, honoured only in IDLE
//   itile      in  TILE_W        tile index, sampled with istart
//   irow       in  ROW_W         row index, sampled with istart
//   iflip      in  1             horizontal mirror request, sampled with istart
//   orom_en    out 1             ROM read enable, one-cycle pulse
//   orom_addr  out TILE_W+ROW_W  ROM address {tile,row}, holds last value
//   irom_data  in  DATA_WIDTH    ROM read data, valid ROM_LAT cycles after orom_en
//   odata      out DATA_WIDTH    row word, holds until the next owr
//   owr        out 1             write strobe to ping-pong buffer
//   obusy      out 1             fetch in progress (any state but IDLE)
//   odrop      out 1             one-cycle pulse: previous-cycle istart rejected
module tile_row_fetch
  import tile_row_fetch_pkg::*;
#(
  parameter int unsigned TILE_W     = TILE_W_DEF,
  parameter int unsigned ROW_W      = ROW_W_DEF,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROM_LAT    = 2
) (
  input  logic                    iclk,
  input  logic                    irst_n,
  input  logic                    istart,
  input  logic [TILE_W-1:0]       itile,
  input  logic [ROW_W-1:0]        irow,
  input  logic                    iflip,
  output logic                    orom_en,
  output logic [TILE_W+ROW_W-1:0] orom_addr,
  input  logic [DATA_WIDTH-1:0]   irom_data,
  output logic [DATA_WIDTH-1:0]   odata,
  output logic                    owr,
  output logic                    obusy,
  output logic                    odrop
);

  // Wait counter covers ROM_LAT-1 for the legal latency range 1..7.
  localparam logic [2:0] CNT_INIT = 3'(ROM_LAT - 1);

  fetch_state_t            state, state_nxt;
  logic [2:0]              cnt;
  logic                    accept;
  logic                    capture;
  logic [DATA_WIDTH-1:0]   row_in;

`ifdef TILE_ROW_FETCH_FLIP_EN
  logic                    flip_q;
  logic [DATA_WIDTH-1:0]   row_mirrored;

  row_mirror #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_row_mirror (
    .din  (irom_data),
    .dout (row_mirrored)
  );

  assign row_in = flip_q ? row_mirrored : irom_data;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      flip_q <= 1'b0;
    end else if (accept) begin
      flip_q <= iflip;
    end
  end
`else
  logic unused_iflip;

  assign unused_iflip = iflip;
  assign row_in       = irom_data;
`endif

  // Next state and decoded outputs; orom_en/owr/obusy decode straight from
  // the state register so they are zero while reset is held.
  always_comb begin
    state_nxt = state;
    orom_en   = 1'b0;
    owr       = 1'b0;
    obusy     = 1'b1;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        obusy = 1'b0;
        if (istart) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        orom_en   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // Counter at zero marks the cycle irom_data is valid.
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        owr       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      orom_addr <= '0;
      odata     <= '0;
      odrop     <= 1'b0;
    end else begin
      state <= state_nxt;
      odrop <= istart & obusy;

      if (accept) begin
        orom_addr <= {itile, irow};
      end

      if (state == REQ) begin
        cnt <= CNT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 3'd1;
      end

      if (capture) begin
        odata <= row_in;
      end
    end
  end

endmodule

// File: tb/tb_tile_row_fetch.sv
module tb_tile_row_fetch;

  logic        iclk;
  logic        irst_n;
  logic        istart;
  logic [7:0]  itile;
  logic [2:0]  irow;
  logic        iflip;

  logic        rom_en2, owr2, busy2, drop2;
  logic [10:0] addr2;
  logic [7:0]  romd2, data2;

  logic        rom_en1, owr1, busy1, drop1;
  logic [10:0] addr1;
  logic [7:0]  romd1, data1;

  logic [7:0]  rom_word;

  int          checks;
  int          errors;

`ifdef TILE_ROW_FETCH_FLIP_EN
  localparam bit FLIP_BUILD = 1'b1;
`else
  localparam bit FLIP_BUILD = 1'b0;
`endif

  tile_row_fetch #(
    .TILE_W     (8),
    .ROW_W      (3),
    .DATA_WIDTH (8),
    .ROM_LAT    (2)
  ) dut (
    .iclk      (iclk),
    .irst_n    (irst_n),
    .istart    (istart),
    .itile     (itile),
    .irow      (irow),
    .iflip     (iflip),
    .orom_en   (rom_en2),
    .orom_addr (addr2),
    .irom_data (romd2),
    .odata     (data2),
    .owr       (owr2),
    .obusy     (busy2),
    .odrop     (drop2)
  );

  tile_row_fetch #(
    .TILE_W     (8),
    .ROW_W      (3),
    .DATA_WIDTH (8),
    .ROM_LAT    (1)
  ) dut_lat1 (
    .iclk      (iclk),
    .irst_n    (irst_n),
    .istart    (istart),
    .itile     (itile),
    .irow      (irow),
    .iflip     (iflip),
    .orom_en   (rom_en1),
    .orom_addr (addr1),
    .irom_data (romd1),
    .odata     (data1),
    .owr       (owr1),
    .obusy     (busy1),
    .odrop     (drop1)
  );

  // ROM models: rom_word appears ROM_LAT cycles after the enable cycle;
  // any other cycle shows 0xEE so a mistimed capture is visible.
  logic [7:0] rp2 [2];
  logic [7:0] rp1;

  always @(posedge iclk) begin
    rp2[0] <= rom_en2 ? rom_word : 8'hEE;
    rp2[1] <= rp2[0];
    rp1    <= rom_en1 ? rom_word : 8'hEE;
  end

  assign romd2 = rp2[1];
  assign romd1 = rp1;

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct {
    logic [7:0]  tile;
    logic [2:0]  row;
    logic        flip;
    logic [7:0]  rom;
    logic [10:0] addr;
    logic [7:0]  d_plain;
    logic [7:0]  d_flip;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  // Full fetch on the ROM_LAT=2 instance; istart in cycle 0, owr in cycle 4.
  task automatic do_fetch(input vec_t v);
    logic [7:0] exp_d;
    exp_d    = FLIP_BUILD ? v.d_flip : v.d_plain;
    rom_word = v.rom;
    itile    = v.tile;
    irow     = v.row;
    iflip    = v.flip;
    istart   = 1'b1;
    chk("c0_busy", busy2, 0);
    step();
    istart = 1'b0;
    itile  = 8'h00;
    irow   = 3'd0;
    iflip  = 1'b0;
    chk("c1_rom_en", rom_en2, 1);
    chk("c1_addr", addr2, v.addr);
    chk("c1_busy", busy2, 1);
    step();
    chk("c2_rom_en", rom_en2, 0);
    chk("c2_busy", busy2, 1);
    step();
    chk("c3_busy", busy2, 1);
    chk("c3_owr", owr2, 0);
    step();
    chk("c4_owr", owr2, 1);
    chk("c4_data", data2, exp_d);
    chk("c4_busy", busy2, 1);
    step();
    chk("c5_owr", owr2, 0);
    chk("c5_busy", busy2, 0);
    chk("c5_data_hold", data2, exp_d);
  endtask

  initial begin
    int owr_cnt;
    checks   = 0;
    errors   = 0;
    irst_n   = 1'b0;
    istart   = 1'b0;
    itile    = 8'h00;
    irow     = 3'd0;
    iflip    = 1'b0;
    rom_word = 8'h00;

    //            tile   row   flip  rom    addr      plain  flipped
    vecs[0] = '{8'h05, 3'd3, 1'b0, 8'hC3, 11'h02B, 8'hC3, 8'hC3};
    vecs[1] = '{8'h12, 3'd7, 1'b1, 8'h81, 11'h097, 8'h81, 8'h81};
    vecs[2] = '{8'hFF, 3'd0, 1'b1, 8'hF0, 11'h7F8, 8'hF0, 8'h0F};
    vecs[3] = '{8'h00, 3'd0, 1'b0, 8'h5A, 11'h000, 8'h5A, 8'h5A};
    vecs[4] = '{8'hA5, 3'd5, 1'b1, 8'h01, 11'h52D, 8'h01, 8'h80};

    #25 irst_n = 1'b1;

    // Reset release, idle for 20 cycles: every output stays 0.
    for (int k = 0; k < 20; k++) begin
      step();
      chk("idle_outputs", {rom_en2, addr2, data2, owr2, busy2, drop2}, 0);
    end

    // Table-driven single fetches.
    for (int i = 0; i < 5; i++) begin
      do_fetch(vecs[i]);
      step();
    end

    // Requests during an active fetch: cycles 2 (WAIT) and 4 (DONE).
    rom_word = 8'h3C;
    itile    = 8'h05;
    irow     = 3'd3;
    iflip    = 1'b0;
    istart   = 1'b1;
    owr_cnt  = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      istart = (k == 2 || k == 4);
      itile  = (k == 2) ? 8'h33 : 8'h05;
      irow   = (k == 2) ? 3'd6 : 3'd3;
      chk("drop_pulse", drop2, (k == 3 || k == 5));
      chk("drop_addr_hold", addr2, 11'h02B);
      if (owr2) owr_cnt++;
      if (k == 4) chk("drop_data", data2, 8'h3C);
    end
    istart = 1'b0;
    chk("drop_single_owr", owr_cnt, 1);
    chk("drop_idle_after", busy2, 0);
    repeat (4) step();

    // istart held for 30 cycles on the ROM_LAT=1 instance.
    rom_word = 8'h6E;
    itile    = 8'h21;
    irow     = 3'd2;
    iflip    = 1'b0;
    istart   = 1'b1;
    chk("hold_c0_drop", drop1, 0);
    chk("hold_c0_owr", owr1, 0);
    for (int k = 1; k < 30; k++) begin
      step();
      chk("hold_owr", owr1, (k % 4 == 3));
      chk("hold_drop", drop1, (k >= 2 && (k % 4 != 1)));
      if (k % 4 == 3) chk("hold_data", data1, 8'h6E);
    end
    istart = 1'b0;
    repeat (8) step();

    // Asynchronous reset during WAIT: outputs clear, no owr afterwards.
    rom_word = 8'h99;
    itile    = 8'h0A;
    irow     = 3'd1;
    istart   = 1'b1;
    step();
    istart = 1'b0;
    step();
    chk("rst_pre_busy", busy2, 1);
    #2 irst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {rom_en2, addr2, data2, owr2, busy2, drop2}, 0);
    @(negedge iclk);
    @(negedge iclk);
    irst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rst_no_owr", owr2, 0);
      chk("rst_data_zero", data2, 0);
    end
    do_fetch(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
